// File: rtl/dual_tone_stimulus_nco.sv
// Two-tone pipelined NCO with double-buffered tuning, summed and saturated output.
// Optional SAT_COUNT_EN adds a saturating count of clipped output samples.
module dual_tone_stimulus_nco #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned PHASE_WIDTH    = 24,
    parameter int unsigned LUT_ADDR_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sample_en_i,
    input  logic                   enable_i,
    input  logic                   cfg_load_i,
    input  logic [PHASE_WIDTH-1:0] ftw1_i,
    input  logic [PHASE_WIDTH-1:0] ftw2_i,
    input  logic [15:0]            amp1_i,
    input  logic [15:0]            amp2_i,
    output logic [DATA_WIDTH-1:0]  tone_out_o,
    output logic                   tone_valid_o,
    output logic                   cfg_pending_o,
    output logic                   sat_flag_o
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]            sat_count_o
`endif
);

    localparam int unsigned LutDepth = 1 << LUT_ADDR_WIDTH;
    localparam int unsigned PhW      = LUT_ADDR_WIDTH + 2;
    localparam logic signed [17:0] SatMax = 18'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [17:0] SatMin = -SatMax - 18'sd1;

    // Quarter-wave entries sampled at bin centres, so no fold ever hits sin=0 or 1 exactly.
    function automatic logic [15:0] lut_entry(input int unsigned k);
        real x;
        x = 32767.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(LutDepth));
        return 16'($rtoi(x + 0.5));
    endfunction

    logic [15:0] lut_rom [LutDepth];
    for (genvar k = 0; k < LutDepth; k++) begin : g_lut
        assign lut_rom[k] = lut_entry(k);
    end

    logic                   accept;
    logic [PHASE_WIDTH-1:0] phase1_q, phase1_d, phase2_q, phase2_d;
    logic [PHASE_WIDTH-1:0] sh_ftw1_q, sh_ftw1_d, sh_ftw2_q, sh_ftw2_d;
    logic [PHASE_WIDTH-1:0] act_ftw1_q, act_ftw1_d, act_ftw2_q, act_ftw2_d;
    logic [15:0]            sh_amp1_q, sh_amp1_d, sh_amp2_q, sh_amp2_d;
    logic [15:0]            act_amp1_q, act_amp1_d, act_amp2_q, act_amp2_d;
    logic [PHASE_WIDTH-1:0] use_ftw1, use_ftw2;
    logic [15:0]            use_amp1, use_amp2;
    logic                   cfg_pending_q, cfg_pending_d;

    logic                   s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
    logic [PhW-1:0]         s1_ph1_q, s1_ph2_q;
    logic [15:0]            s1_amp1_q, s1_amp2_q, s2_amp1_q, s2_amp2_q;
    logic [LUT_ADDR_WIDTH-1:0] addr1, addr2;
    logic signed [16:0]     mag1, mag2, lut1_d, lut2_d, s2_lut1_q, s2_lut2_q;
    logic signed [32:0]     prod1, prod2;
    logic signed [16:0]     tone1_d, tone2_d, s3_tone1_q, s3_tone2_q;
    logic signed [17:0]     sum_d, s4_sum_q;
    logic                   clip;
    logic [DATA_WIDTH-1:0]  sat_val, tone_out_q, tone_out_d;
    logic                   tone_valid_q, sat_flag_q, sat_flag_d;

    always_comb begin
        accept   = sample_en_i & enable_i;
        // A pending shadow is applied to the very sample that promotes it.
        use_ftw1 = cfg_pending_q ? sh_ftw1_q : act_ftw1_q;
        use_ftw2 = cfg_pending_q ? sh_ftw2_q : act_ftw2_q;
        use_amp1 = cfg_pending_q ? sh_amp1_q : act_amp1_q;
        use_amp2 = cfg_pending_q ? sh_amp2_q : act_amp2_q;

        phase1_d   = accept ? phase1_q + use_ftw1 : phase1_q;
        phase2_d   = accept ? phase2_q + use_ftw2 : phase2_q;
        act_ftw1_d = accept ? use_ftw1 : act_ftw1_q;
        act_ftw2_d = accept ? use_ftw2 : act_ftw2_q;
        act_amp1_d = accept ? use_amp1 : act_amp1_q;
        act_amp2_d = accept ? use_amp2 : act_amp2_q;
        sh_ftw1_d  = cfg_load_i ? ftw1_i : sh_ftw1_q;
        sh_ftw2_d  = cfg_load_i ? ftw2_i : sh_ftw2_q;
        sh_amp1_d  = cfg_load_i ? amp1_i : sh_amp1_q;
        sh_amp2_d  = cfg_load_i ? amp2_i : sh_amp2_q;
        cfg_pending_d = cfg_load_i | (cfg_pending_q & ~accept);

        addr1  = s1_ph1_q[LUT_ADDR_WIDTH-1:0] ^ {LUT_ADDR_WIDTH{s1_ph1_q[PhW-2]}};
        addr2  = s1_ph2_q[LUT_ADDR_WIDTH-1:0] ^ {LUT_ADDR_WIDTH{s1_ph2_q[PhW-2]}};
        mag1   = {1'b0, lut_rom[addr1]};
        mag2   = {1'b0, lut_rom[addr2]};
        lut1_d = s1_ph1_q[PhW-1] ? -mag1 : mag1;
        lut2_d = s1_ph2_q[PhW-1] ? -mag2 : mag2;

        prod1   = 33'(s2_lut1_q) * 33'($signed({1'b0, s2_amp1_q}));
        prod2   = 33'(s2_lut2_q) * 33'($signed({1'b0, s2_amp2_q}));
        tone1_d = 17'(prod1 >>> 16);
        tone2_d = 17'(prod2 >>> 16);
        sum_d   = 18'(s3_tone1_q) + 18'(s3_tone2_q);

        clip = 1'b0;
        if (s4_sum_q > SatMax) begin
            sat_val = SatMax[DATA_WIDTH-1:0];
            clip    = 1'b1;
        end else if (s4_sum_q < SatMin) begin
            sat_val = SatMin[DATA_WIDTH-1:0];
            clip    = 1'b1;
        end else begin
            sat_val = s4_sum_q[DATA_WIDTH-1:0];
        end
        tone_out_d = s4_valid_q ? sat_val : tone_out_q;
        sat_flag_d = cfg_load_i ? 1'b0 : (sat_flag_q | (s4_valid_q & clip));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase1_q      <= '0;
            phase2_q      <= '0;
            sh_ftw1_q     <= '0;
            sh_ftw2_q     <= '0;
            sh_amp1_q     <= '0;
            sh_amp2_q     <= '0;
            act_ftw1_q    <= '0;
            act_ftw2_q    <= '0;
            act_amp1_q    <= '0;
            act_amp2_q    <= '0;
            cfg_pending_q <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_ph1_q      <= '0;
            s1_ph2_q      <= '0;
            s1_amp1_q     <= '0;
            s1_amp2_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_lut1_q     <= '0;
            s2_lut2_q     <= '0;
            s2_amp1_q     <= '0;
            s2_amp2_q     <= '0;
            s3_valid_q    <= 1'b0;
            s3_tone1_q    <= '0;
            s3_tone2_q    <= '0;
            s4_valid_q    <= 1'b0;
            s4_sum_q      <= '0;
            tone_out_q    <= '0;
            tone_valid_q  <= 1'b0;
            sat_flag_q    <= 1'b0;
        end else begin
            phase1_q      <= phase1_d;
            phase2_q      <= phase2_d;
            sh_ftw1_q     <= sh_ftw1_d;
            sh_ftw2_q     <= sh_ftw2_d;
            sh_amp1_q     <= sh_amp1_d;
            sh_amp2_q     <= sh_amp2_d;
            act_ftw1_q    <= act_ftw1_d;
            act_ftw2_q    <= act_ftw2_d;
            act_amp1_q    <= act_amp1_d;
            act_amp2_q    <= act_amp2_d;
            cfg_pending_q <= cfg_pending_d;
            s1_valid_q    <= accept;
            if (accept) begin
                s1_ph1_q  <= phase1_q[PHASE_WIDTH-1 -: PhW];
                s1_ph2_q  <= phase2_q[PHASE_WIDTH-1 -: PhW];
                s1_amp1_q <= use_amp1;
                s1_amp2_q <= use_amp2;
            end
            s2_valid_q    <= s1_valid_q;
            s2_lut1_q     <= lut1_d;
            s2_lut2_q     <= lut2_d;
            s2_amp1_q     <= s1_amp1_q;
            s2_amp2_q     <= s1_amp2_q;
            s3_valid_q    <= s2_valid_q;
            s3_tone1_q    <= tone1_d;
            s3_tone2_q    <= tone2_d;
            s4_valid_q    <= s3_valid_q;
            s4_sum_q      <= sum_d;
            tone_out_q    <= tone_out_d;
            tone_valid_q  <= s4_valid_q;
            sat_flag_q    <= sat_flag_d;
        end
    end

`ifdef SAT_COUNT_EN
    logic [15:0] sat_count_q, sat_count_d;

    always_comb begin
        sat_count_d = sat_count_q;
        if (cfg_load_i) begin
            sat_count_d = '0;
        end else if (s4_valid_q && clip && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count_o = sat_count_q;
`endif

    assign tone_out_o    = tone_out_q;
    assign tone_valid_o  = tone_valid_q;
    assign cfg_pending_o = cfg_pending_q;
    assign sat_flag_o    = sat_flag_q;

endmodule

// File: tb/tb_dual_tone_stimulus_nco.sv
// Directed bench for dual_tone_stimulus_nco: DC, quarter-rate, saturation,
// coincident retune, enable hold and mid-stream reset, against hand-computed samples.
module tb_dual_tone_stimulus_nco;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_en, enable, cfg_load;
    logic [23:0]        ftw1, ftw2;
    logic [15:0]        amp1, amp2;
    logic signed [15:0] tone_out;
    logic               tone_valid, cfg_pending, sat_flag;
`ifdef SAT_COUNT_EN
    logic [15:0]        sat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dual_tone_stimulus_nco #(
        .DATA_WIDTH    (16),
        .PHASE_WIDTH   (24),
        .LUT_ADDR_WIDTH(8)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sample_en_i  (sample_en),
        .enable_i     (enable),
        .cfg_load_i   (cfg_load),
        .ftw1_i       (ftw1),
        .ftw2_i       (ftw2),
        .amp1_i       (amp1),
        .amp2_i       (amp2),
        .tone_out_o   (tone_out),
        .tone_valid_o (tone_valid),
        .cfg_pending_o(cfg_pending),
        .sat_flag_o   (sat_flag)
`ifdef SAT_COUNT_EN
        ,
        .sat_count_o  (sat_count)
`endif
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_cfg(input logic [23:0] f1, input logic [23:0] f2,
                           input logic [15:0] a1, input logic [15:0] a2);
        ftw1 = f1;
        ftw2 = f2;
        amp1 = a1;
        amp2 = a2;
    endtask

    task automatic load_cfg(input logic [23:0] f1, input logic [23:0] f2,
                            input logic [15:0] a1, input logic [15:0] a2);
        set_cfg(f1, f2, a1, a2);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // One strobe, then check the 4-cycle latency and the produced sample.
    task automatic do_sample(input string tag, input int exp_v, input bit with_cfg);
        sample_en = 1'b1;
        cfg_load  = with_cfg;
        @(negedge clk);
        sample_en = 1'b0;
        cfg_load  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, "_early"}, 32'(tone_valid), 0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(tone_valid), 1);
        check_eq({tag, "_data"}, 32'(tone_out), exp_v);
    endtask

    initial begin
        bit saw_valid;
        rst_n     = 1'b0;
        sample_en = 1'b1;
        enable    = 1'b1;
        cfg_load  = 1'b0;
        set_cfg(24'h0, 24'h0, 16'h0, 16'h0);

        // Reset held with strobes active: everything stays clear.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_valid", 32'(tone_valid), 0);
        end
        check_eq("rst_out", 32'(tone_out), 0);
        check_eq("rst_sat", 32'(sat_flag), 0);
        check_eq("rst_pend", 32'(cfg_pending), 0);
        sample_en = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // DC tone, with a discarded first load (last capture wins).
        load_cfg(24'h000005, 24'h0, 16'h1234, 16'h0);
        load_cfg(24'h0, 24'h0, 16'hFFFF, 16'h0);
        check_eq("dc_pend_set", 32'(cfg_pending), 1);
        do_sample("dc0", 100, 1'b0);
        check_eq("dc_pend_clr", 32'(cfg_pending), 0);
        do_sample("dc1", 100, 1'b0);
        do_sample("dc2", 100, 1'b0);

        // Quarter-rate tone; an enable-low strobe in the middle must not advance phase.
        load_cfg(24'h400000, 24'h0, 16'hFFFF, 16'h0);
        do_sample("qr0", 100, 1'b0);
        do_sample("qr1", 32766, 1'b0);
        enable    = 1'b0;
        sample_en = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid |= tone_valid;
        end
        check_eq("en_low_novalid", 32'(saw_valid), 0);
        enable    = 1'b1;
        sample_en = 1'b0;
        do_sample("qr2", -101, 1'b0);
        do_sample("qr3", -32767, 1'b0);
        check_eq("qr_nosat", 32'(sat_flag), 0);

        // Both tones full scale: clips on the peaks.
        load_cfg(24'h400000, 24'h400000, 16'hFFFF, 16'hFFFF);
        do_sample("sat0", 200, 1'b0);
        check_eq("sat_flag0", 32'(sat_flag), 0);
        do_sample("sat1", 32767, 1'b0);
        check_eq("sat_flag1", 32'(sat_flag), 1);
        do_sample("sat2", -202, 1'b0);
        do_sample("sat3", -32768, 1'b0);
        check_eq("sat_sticky", 32'(sat_flag), 1);

        // Retune clears sat_flag; then a cfg_load coincident with a strobe.
        load_cfg(24'h400000, 24'h0, 16'hFFFF, 16'h0);
        check_eq("sat_clr", 32'(sat_flag), 0);
        do_sample("co0", 100, 1'b0);
        set_cfg(24'h400000, 24'h0, 16'h0, 16'h0);
        do_sample("co1", 32766, 1'b1);
        check_eq("co_pend", 32'(cfg_pending), 1);
        do_sample("co2", 0, 1'b0);
        check_eq("co_pend_clr", 32'(cfg_pending), 0);

        // Mid-stream reset with a full pipeline.
        load_cfg(24'h400000, 24'h0, 16'hFFFF, 16'h0);
        sample_en = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("ms_running", 32'(tone_valid), 1);
        rst_n = 1'b0;
        #1;
        check_eq("ms_out_clr", 32'(tone_out), 0);
        check_eq("ms_valid_clr", 32'(tone_valid), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        sample_en = 1'b0;
        saw_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_valid |= tone_valid;
        end
        check_eq("ms_drained", 32'(saw_valid), 0);
        do_sample("ms_first", 0, 1'b0);
        load_cfg(24'h400000, 24'h0, 16'hFFFF, 16'h0);
        do_sample("ms_phase0", 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
